// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution MAC: FSM states, datapath widths,
// and the rounding-constant helper used by the output stage.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } conv_state_e;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 9;
    localparam int PROD_W = 18;
    localparam int SUM_W  = 22;
    localparam int TAPS   = 9;

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic [PIX_W-1:0]         pix_t;

    // Half an LSB of the shifted result, so the shift rounds to nearest (ties upward).
    function automatic int round_const(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

endpackage

// File: rtl/conv_dot9.sv
// Two-stage 9-tap dot product: S1 registers the signed products, S2 sums, rounds,
// shifts and clamps to 0..255. Both stages advance only when pipe_en is high.
module conv_dot9
    import conv_pkg::*;
#(
    parameter int SHIFT = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_en,
    input  logic                     in_valid,
    input  logic [TAPS*COEF_W-1:0]   coeffs,
    input  logic [TAPS*PIX_W-1:0]    pixels,
    output logic                     s1_valid,
    output logic                     out_valid,
    output logic [PIX_W-1:0]         out_data
`ifdef CONV_CLIP_STATS_EN
    ,
    output logic                     clip_now
`endif
);

    localparam int RND = round_const(SHIFT);

    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [PROD_W-1:0] prod_d [TAPS];
    logic                     s1_valid_q, s1_valid_d;
    logic                     out_valid_q, out_valid_d;
    logic [PIX_W-1:0]         out_data_q, out_data_d;

    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W:0]    rnd;
    logic signed [SUM_W:0]    shifted;
    logic                     is_neg;
    logic                     is_over;

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = prod_q[i];
            if (pipe_en && in_valid) begin
                prod_d[i] = $signed(coeffs[i*COEF_W +: COEF_W]) *
                            $signed({1'b0, pixels[i*PIX_W +: PIX_W]});
            end
        end
        s1_valid_d = pipe_en ? in_valid : s1_valid_q;
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) begin
            sum = sum + {{(SUM_W-PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
        rnd     = {sum[SUM_W-1], sum} + (SUM_W+1)'(RND);
        shifted = rnd >>> SHIFT;
        is_neg  = shifted[SUM_W];
        is_over = !is_neg && (|shifted[SUM_W-1:PIX_W]);

        out_valid_d = pipe_en ? s1_valid_q : out_valid_q;
        out_data_d  = out_data_q;
        if (pipe_en && s1_valid_q) begin
            out_data_d = is_neg ? '0 : (is_over ? '1 : shifted[PIX_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign s1_valid  = s1_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
`ifdef CONV_CLIP_STATS_EN
    assign clip_now  = s1_valid_q && (is_neg || is_over);
`endif

endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: job FSM (IDLE/LOAD/RUN/DRAIN), window counting and handshakes around conv_dot9.
// Define CONV_CLIP_STATS_EN to add the clip_count output (clamped results in the current job).
module conv3x3_mac
    import conv_pkg::*;
#(
    parameter int SHIFT = 7,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pixel_count_valid,
    output logic                     pixel_count_ready,
    input  logic [CNT_W-1:0]         pixel_count,
    input  logic                     coeffs_valid,
    output logic                     coeffs_ready,
    input  logic [TAPS*COEF_W-1:0]   coeffs_data,
    input  logic                     window_valid,
    output logic                     window_ready,
    input  logic [TAPS*PIX_W-1:0]    window_data,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [PIX_W-1:0]         result_data
`ifdef CONV_CLIP_STATS_EN
    ,
    output logic [CNT_W-1:0]         clip_count
`endif
);

    conv_state_e               state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [CNT_W-1:0]          acc_q, acc_d;
    logic [TAPS*COEF_W-1:0]    coef_q, coef_d;
    logic                      live_q, live_d;

    logic pipe_en;
    logic pc_fire;
    logic win_fire;
    logic s1_valid;

    // live_q keeps pixel_count_ready low while reset is held, even though state is IDLE.
    assign pipe_en           = !result_valid || result_ready;
    assign pixel_count_ready = live_q && (state_q == IDLE);
    assign coeffs_ready      = (state_q == LOAD);
    assign window_ready      = (state_q == RUN) && pipe_en && (acc_q < count_q);
    assign pc_fire           = pixel_count_valid && pixel_count_ready;
    assign win_fire          = window_valid && window_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        coef_d  = coef_q;
        live_d  = 1'b1;
        case (state_q)
            IDLE: begin
                if (pc_fire) begin
                    count_d = pixel_count;
                    acc_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (coeffs_valid) begin
                    coef_d  = coeffs_data;
                    state_d = (count_q == '0) ? IDLE : RUN;
                end
            end
            RUN: begin
                if (win_fire) begin
                    acc_d = acc_q + 1'b1;
                    if (acc_d == count_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave in the same cycle the final result is handed off.
                if (!s1_valid && pipe_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            coef_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            coef_q  <= coef_d;
            live_q  <= live_d;
        end
    end

`ifdef CONV_CLIP_STATS_EN
    logic             clip_now;
    logic [CNT_W-1:0] clip_q, clip_d;

    always_comb begin
        clip_d = clip_q;
        if (state_q == IDLE && pc_fire) begin
            clip_d = '0;
        end else if (pipe_en && clip_now && (clip_q != '1)) begin
            clip_d = clip_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) clip_q <= '0;
        else      clip_q <= clip_d;
    end

    assign clip_count = clip_q;
`endif

    conv_dot9 #(
        .SHIFT (SHIFT)
    ) u_dot9 (
        .clk       (clk),
        .rst       (rst),
        .pipe_en   (pipe_en),
        .in_valid  (win_fire),
        .coeffs    (coef_q),
        .pixels    (window_data),
        .s1_valid  (s1_valid),
        .out_valid (result_valid),
        .out_data  (result_data)
`ifdef CONV_CLIP_STATS_EN
        ,
        .clip_now  (clip_now)
`endif
    );

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: randomized and directed jobs, scoreboard fed by an arithmetic reference model.
module tb_conv3x3_mac;

    localparam int SHIFT   = 7;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 2000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pixel_count_valid = 1'b0;
    logic          pixel_count_ready;
    logic [CNT_W-1:0] pixel_count = '0;
    logic          coeffs_valid = 1'b0;
    logic          coeffs_ready;
    logic [80:0]   coeffs_data = '0;
    logic          window_valid = 1'b0;
    logic          window_ready;
    logic [71:0]   window_data = '0;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [7:0]    result_data;
`ifdef CONV_CLIP_STATS_EN
    logic [CNT_W-1:0] clip_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [80:0] cur_coef = '0;
    int          job_cnt = 0;
    int          win_acc = 0;
    int          job_clips = 0;
    int          rr_mode = 0;

    conv3x3_mac #(
        .SHIFT (SHIFT),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pixel_count_valid (pixel_count_valid),
        .pixel_count_ready (pixel_count_ready),
        .pixel_count       (pixel_count),
        .coeffs_valid      (coeffs_valid),
        .coeffs_ready      (coeffs_ready),
        .coeffs_data       (coeffs_data),
        .window_valid      (window_valid),
        .window_ready      (window_ready),
        .window_data       (window_data),
        .result_valid      (result_valid),
        .result_ready      (result_ready),
        .result_data       (result_data)
`ifdef CONV_CLIP_STATS_EN
        ,
        .clip_count        (clip_count)
`endif
    );

    // ---------------- clock / result_ready pattern ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       result_ready = 1'b1;
            1:       result_ready = ~result_ready;
            default: result_ready = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Exact integer convolution, round-half-up division by 2^SHIFT, clamp to a byte.
    function automatic int ref_pix(input logic [80:0] cf, input logic [71:0] px, output bit clip);
        int s;
        int t;
        int q;
        int div;
        logic signed [8:0] c;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            c = cf[i*9 +: 9];
            s += int'(c) * int'(px[i*8 +: 8]);
        end
        div = 1 << SHIFT;
        t   = s + div / 2;
        if (t >= 0) q = t / div;
        else        q = -((-t + div - 1) / div);
        clip = (q < 0) || (q > 255);
        if (q < 0)   q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d with no result expected at %0t", result_data, $time);
            end else begin
                chk("result_data", 32'(result_data), 32'(exp_q[0]));
                if (result_ready) void'(exp_q.pop_front());
            end
        end
        if (rst && window_valid && window_ready) win_acc++;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int which, input string name, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < TIMEOUT; t++) begin
            @(negedge clk);
            if ((which == 0 && pixel_count_ready) || (which == 1 && coeffs_ready) ||
                (which == 2 && window_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: ready not seen within %0d cycles", name, TIMEOUT);
        end
    endtask

    task automatic start_job(input int cnt, input logic [80:0] cf);
        bit ok;
        job_cnt   = cnt;
        win_acc   = 0;
        job_clips = 0;
        cur_coef  = cf;
        pixel_count       = CNT_W'(cnt);
        pixel_count_valid = 1'b1;
        wait_ready(0, "pixel_count_ready", ok);
        @(posedge clk); #1;
        pixel_count_valid = 1'b0;
        coeffs_data  = cf;
        coeffs_valid = 1'b1;
        wait_ready(1, "coeffs_ready", ok);
        @(posedge clk); #1;
        coeffs_valid = 1'b0;
    endtask

    // exp_lit < 0 means "use the reference model value".
    task automatic send_window(input logic [71:0] w, input int exp_lit);
        bit ok;
        bit clip;
        int m;
        window_data  = w;
        window_valid = 1'b1;
        wait_ready(2, "window_ready", ok);
        if (ok) begin
            m = ref_pix(cur_coef, w, clip);
            if (clip) job_clips++;
            exp_q.push_back(8'((exp_lit >= 0) ? exp_lit : m));
        end
        @(posedge clk); #1;
    endtask

    // Offers a junk window throughout the drain so an extra acceptance would be seen.
    task automatic end_job(input string name);
        bit done;
        done = 1'b0;
        window_data  = {9{8'hA5}};
        window_valid = 1'b1;
        for (int t = 0; t < TIMEOUT; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pixel_count_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_drain: %0d results outstanding after %0d cycles", name, exp_q.size(), TIMEOUT);
            exp_q.delete();
        end
        @(posedge clk); #1;
        window_valid = 1'b0;
        chk({name, "_windows_accepted"}, 32'(win_acc), 32'(job_cnt));
`ifdef CONV_CLIP_STATS_EN
        chk({name, "_clip_count"}, 32'(clip_count), 32'(job_clips));
`endif
    endtask

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    function automatic logic [80:0] rand_coef(input int span);
        logic [80:0] cf;
        int v;
        for (int i = 0; i < 9; i++) begin
            v = int'($urandom_range(0, 2 * span)) - span;
            cf[i*9 +: 9] = 9'(v);
        end
        return cf;
    endfunction

    function automatic logic [71:0] center_win(input int pix);
        logic [71:0] w;
        w = rand_win();
        w[32 +: 8] = 8'(pix);
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [80:0] cf;
        logic [71:0] w;

        repeat (2) @(negedge clk);
        chk("reset_pixel_count_ready", 32'(pixel_count_ready), 0);
        chk("reset_coeffs_ready", 32'(coeffs_ready), 0);
        chk("reset_window_ready", 32'(window_ready), 0);
        chk("reset_result_valid", 32'(result_valid), 0);
        chk("reset_result_data", 32'(result_data), 0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;

        // Identity kernel: output equals the centre pixel.
        rr_mode = 0;
        cf = '0;
        cf[36 +: 9] = 9'd128;
        start_job(256, cf);
        for (int i = 0; i < 256; i++) send_window(center_win(i), i);
        end_job("identity");

        // Clamp low and clamp high.
        cf = {9{9'h1FF}};
        start_job(1, cf);
        send_window({9{8'd255}}, 0);
        end_job("clamp_low");
        cf = {9{9'd255}};
        start_job(2, cf);
        send_window({9{8'd255}}, 255);
        send_window({9{8'd255}}, 255);
        end_job("clamp_high");

        // Round-half-up at SHIFT=7.
        cf = '0;
        cf[36 +: 9] = 9'd1;
        start_job(4, cf);
        send_window(center_win(64), 1);
        send_window(center_win(63), 0);
        send_window(center_win(191), 1);
        send_window(center_win(192), 2);
        end_job("rounding");

        // Alternating backpressure.
        rr_mode = 1;
        start_job(4, rand_coef(40));
        for (int i = 0; i < 4; i++) send_window(rand_win(), -1);
        end_job("backpressure");

        // Zero-length job followed by a job with a different coefficient set.
        rr_mode = 0;
        cf = '0;
        cf[0 +: 9] = 9'd255;
        start_job(0, cf);
        end_job("zero_job");
        cf = '0;
        cf[72 +: 9] = 9'd64;
        start_job(2, cf);
        w = rand_win();
        send_window(w, int'(w[64 +: 8] + 1) / 2);
        send_window({8'd200, 64'd0}, 100);
        end_job("after_zero");

        // Reset in the middle of a running job.
        start_job(10, rand_coef(40));
        for (int i = 0; i < 3; i++) send_window(rand_win(), -1);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_result_valid", 32'(result_valid), 0);
        chk("midreset_pixel_count_ready", 32'(pixel_count_ready), 0);
        chk("midreset_window_ready", 32'(window_ready), 0);
        exp_q.delete();
        window_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("postreset_pixel_count_ready", 32'(pixel_count_ready), 1);
        @(posedge clk); #1;
        start_job(5, rand_coef(60));
        for (int i = 0; i < 5; i++) send_window(rand_win(), -1);
        end_job("post_reset_job");

        // Random jobs with random backpressure.
        rr_mode = 2;
        for (int j = 0; j < 6; j++) begin
            int cnt;
            cnt = int'($urandom_range(1, 20));
            start_job(cnt, rand_coef((j % 2 == 0) ? 40 : 255));
            for (int i = 0; i < cnt; i++) send_window(rand_win(), -1);
            end_job("random_job");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
